lc3_int_ctrl: RTL and testbench

- Parametrised LC-3 interrupt controller. Sits between N peripheral request lines and the CPU's interrupt interface (int_int, int_ld_vec, int_gate_vec, int_vec_mux).
- Each channel has a programmable priority, vector and enable.
- Raises int_int when the best enabled pending request outranks the CPU's current priority level (PSR[10:8]).
- Captures the winning vector on CPU acknowledge and gates x01||vector onto the shared bus.

---
 rtl/lc3_int_ctrl_if.sv | 20 ++
 rtl/lc3_int_ctrl.sv | 104 ++++++++++
 tb/tb_lc3_int_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_int_ctrl_if.sv
// CPU-side interrupt handshake between the LC-3 datapath and lc3_int_ctrl.
interface lc3_int_ctrl_if #(
    parameter int PRIO_W = 3
);
    logic [PRIO_W-1:0] cpu_pl;
    logic [2:0]        int_vec_mux;
    logic              int_ld_vec;
    logic              int_gate_vec;
    logic              int_int;

    modport master (
        output cpu_pl, int_vec_mux, int_ld_vec, int_gate_vec,
        input  int_int
    );

    modport slave (
        input  cpu_pl, int_vec_mux, int_ld_vec, int_gate_vec,
        output int_int
    );
endinterface

// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: per-channel priority/vector/enable, arbitration, vector capture and bus gate.
// Define LC3_INT_EDGE_EN for rising-edge latched requests; default build is level-sensitive.
module lc3_int_ctrl #(
    parameter int N_CH   = 4,
    parameter int PRIO_W = 3,
    parameter int VEC_W  = 8,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   irq,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic              cfg_en,
    input  logic [PRIO_W-1:0] cfg_prio,
    input  logic [VEC_W-1:0]  cfg_vec,
    lc3_int_ctrl_if.slave     cpu,
    output logic [N_CH-1:0]   int_pend,
    inout  wire  [15:0]       bus
);
    logic [N_CH-1:0]   en;
    logic [PRIO_W-1:0] prio [N_CH];
    logic [VEC_W-1:0]  vec  [N_CH];
    logic [VEC_W-1:0]  vec_reg;
    logic [VEC_W-1:0]  win_vec;
    logic [SEL_W-1:0]  win_idx;
    logic [SEL_W-1:0]  cand_idx;
    logic [PRIO_W-1:0] cand_prio;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   pend_next;
    logic              ack;
    logic              int_next;
    logic              win_keep;
    logic [15:0]       bus_val;

    assign eligible = int_pend & en;

    // Strict greater-than keeps the lowest index on ties; starting at 0 means prio 0 never wins.
    always_comb begin
        cand_idx  = '0;
        cand_prio = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (eligible[i] && (prio[i] > cand_prio)) begin
                cand_idx  = SEL_W'(i);
                cand_prio = prio[i];
            end
        end
    end

    assign ack      = cpu.int_ld_vec && (cpu.int_vec_mux == 3'd0) && cpu.int_int;
    assign int_next = (cand_prio > cpu.cpu_pl) && !ack;
    assign win_keep = cpu.int_int && eligible[win_idx] && !(cand_prio > prio[win_idx]);

`ifdef LC3_INT_EDGE_EN
    logic [N_CH-1:0] irq_q;
    logic [N_CH-1:0] clr;

    always_comb begin
        clr = '0;
        if (ack) clr[win_idx] = 1'b1;
    end

    // A fresh edge beats the acknowledge clear of the same channel.
    assign pend_next = en & ((irq & ~irq_q) | (int_pend & ~clr));

    always_ff @(posedge clk) begin
        if (rst) irq_q <= '0;
        else     irq_q <= irq;
    end
`else
    assign pend_next = irq & en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= '0;
            int_pend    <= '0;
            cpu.int_int <= 1'b0;
            vec_reg     <= '0;
            win_idx     <= '0;
            win_vec     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                prio[i] <= '0;
                vec[i]  <= VEC_W'(128 + i);
            end
        end else begin
            int_pend    <= pend_next;
            cpu.int_int <= int_next;
            if (ack) vec_reg <= win_vec;
            if (int_next && !win_keep) begin
                win_idx <= cand_idx;
                win_vec <= vec[cand_idx];
            end
            if (cfg_we) begin
                en[cfg_sel]   <= cfg_en;
                prio[cfg_sel] <= cfg_prio;
                vec[cfg_sel]  <= cfg_vec;
            end
        end
    end

    assign bus_val = (VEC_W <= 8) ? (16'h0100 | 16'(vec_reg)) : 16'(vec_reg);
    assign bus     = cpu.int_gate_vec ? bus_val : 16'hzzzz;
endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Directed plus randomized bench for lc3_int_ctrl against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_lc3_int_ctrl;
    localparam int N  = 4;
    localparam int PW = 3;
    localparam int VW = 8;
    localparam logic [15:0] PAT = 16'h5A3C;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic          cfg_en;
    logic [PW-1:0] cfg_prio;
    logic [VW-1:0] cfg_vec;
    logic [N-1:0]  int_pend;
    wire  [15:0]   bus;
    logic          tb_drv;

    lc3_int_ctrl_if #(.PRIO_W(PW)) cif();

    // The bench drives a known pattern whenever the controller should have released the bus.
    assign tb_drv = ~cif.int_gate_vec;
    assign bus    = tb_drv ? PAT : 16'hzzzz;

    lc3_int_ctrl #(.N_CH(N), .PRIO_W(PW), .VEC_W(VW)) dut (
        .clk(clk), .rst(rst), .irq(irq), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_en(cfg_en), .cfg_prio(cfg_prio), .cfg_vec(cfg_vec),
        .cpu(cif.slave), .int_pend(int_pend), .bus(bus)
    );

    always #5 clk = ~clk;

    bit m_en [N];
    int m_prio [N];
    int m_vec [N];
    bit m_pend [N];
    bit m_irq_q [N];
    bit m_int;
    int m_vreg, m_widx, m_wvec;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [15:0] bus_exp();
        return cif.int_gate_vec ? (16'h0100 | 16'(m_vreg)) : PAT;
    endfunction

    // One clock of the controller described by its rules: best eligible priority wins,
    // request raised only above the CPU level, acknowledge copies the winner's vector.
    task automatic model_step();
        int best, bi;
        bit ack, nint, keep;
        bit np [N];
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_en[i] = 0; m_prio[i] = 0; m_vec[i] = 128 + i; m_pend[i] = 0; m_irq_q[i] = 0;
            end
            m_int = 0; m_vreg = 0; m_widx = 0; m_wvec = 0;
            return;
        end
        best = 0; bi = 0;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i] && m_prio[i] > best) begin best = m_prio[i]; bi = i; end
        ack  = cif.int_ld_vec && (cif.int_vec_mux == 3'd0) && m_int;
        nint = (best > int'(cif.cpu_pl)) && !ack;
        if (ack) m_vreg = m_wvec;
        for (int i = 0; i < N; i++) begin
`ifdef LC3_INT_EDGE_EN
            np[i] = m_en[i] && ((irq[i] && !m_irq_q[i]) || (m_pend[i] && !(ack && m_widx == i)));
`else
            np[i] = m_en[i] && irq[i];
`endif
        end
        keep = m_int && m_pend[m_widx] && m_en[m_widx] && (m_prio[m_widx] == best);
        if (nint && !keep) begin m_widx = bi; m_wvec = m_vec[bi]; end
        for (int i = 0; i < N; i++) begin m_pend[i] = np[i]; m_irq_q[i] = irq[i]; end
        if (cfg_we) begin
            m_en[cfg_sel] = cfg_en; m_prio[cfg_sel] = int'(cfg_prio); m_vec[cfg_sel] = int'(cfg_vec);
        end
        m_int = nint;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("int_int", 32'(cif.int_int), 32'(m_int));
        check("int_pend", 32'(int_pend), 32'(pend_vec()));
        check("bus", 32'(bus), 32'(bus_exp()));
    endtask

    task automatic cfg_write(input int sel, input bit e, input int p, input int v);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_en = e; cfg_prio = PW'(p); cfg_vec = VW'(v);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic gate_check(input string tag, input logic [15:0] exp);
        cif.int_gate_vec = 1'b1;
        #1;
        check(tag, 32'(bus), 32'(exp));
        cif.int_gate_vec = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; irq = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0; cfg_prio = '0; cfg_vec = '0;
        cif.cpu_pl = '0; cif.int_vec_mux = '0; cif.int_ld_vec = 1'b0; cif.int_gate_vec = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_int", 32'(cif.int_int), 32'd0);
        check("rst_pend", 32'(int_pend), 32'd0);
        check("rst_bus", 32'(bus), 32'(PAT));

`ifdef LC3_INT_EDGE_EN
        cif.cpu_pl = 3'd2;
        cfg_write(1, 1, 4, 'h81);
        irq = 4'b0010;
        tick(); tick();
        check("edge_int", 32'(cif.int_int), 32'd1);
        cif.int_ld_vec = 1'b1; tick(); cif.int_ld_vec = 1'b0;
        tick(); tick(); tick();
        check("edge_clr_pend", 32'(int_pend), 32'd0);
        check("edge_no_reassert", 32'(cif.int_int), 32'd0);
        gate_check("edge_bus", 16'h0181);
        irq = 4'b0000; tick();
        irq = 4'b0010; tick(); tick();
        check("edge_reassert", 32'(cif.int_int), 32'd1);
`else
        cif.cpu_pl = 3'd2;
        cfg_write(1, 1, 4, 'h81);
        irq = 4'b0010;
        tick();
        check("lat_pend", 32'(int_pend), 32'b0010);
        check("lat_int_early", 32'(cif.int_int), 32'd0);
        tick();
        check("lat_int", 32'(cif.int_int), 32'd1);
        cif.int_ld_vec = 1'b1; tick(); cif.int_ld_vec = 1'b0;
        check("ack_drop", 32'(cif.int_int), 32'd0);
        gate_check("ack_bus81", 16'h0181);
        irq = 4'b0000; tick(); tick(); tick();
        check("idle_int", 32'(cif.int_int), 32'd0);

        cfg_write(1, 0, 4, 'h81);
        cfg_write(0, 1, 5, 'h80);
        cfg_write(2, 1, 5, 'h82);
        irq = 4'b0101; tick(); tick();
        check("tie_int", 32'(cif.int_int), 32'd1);
        cif.int_ld_vec = 1'b1; tick(); cif.int_ld_vec = 1'b0;
        check("tie_drop", 32'(cif.int_int), 32'd0);
        gate_check("tie_bus80", 16'h0180);
        irq = 4'b0000;
        cfg_write(0, 0, 5, 'h80);
        cfg_write(2, 0, 5, 'h82);
        tick(); tick();

        cfg_write(3, 1, 3, 'h83);
        cif.cpu_pl = 3'd3; irq = 4'b1000;
        tick(); tick(); tick();
        check("pl_block", 32'(cif.int_int), 32'd0);
        cif.cpu_pl = 3'd2; tick(); tick();
        check("pl_release", 32'(cif.int_int), 32'd1);
        cif.cpu_pl = 3'd3; tick();
        check("pl_raise", 32'(cif.int_int), 32'd0);
        irq = 4'b0000; cif.cpu_pl = 3'd2;
        cfg_write(3, 0, 3, 'h83);
        tick();

        cfg_write(1, 1, 4, 'h81);
        irq = 4'b0010; tick();
        cfg_write(2, 1, 6, 'h82);
        irq = 4'b0110; tick(); tick();
        cif.int_ld_vec = 1'b1; tick(); cif.int_ld_vec = 1'b0;
        gate_check("preempt_bus82", 16'h0182);

        irq = 4'b0010; tick(); tick(); tick();
        check("ch1_back", 32'(cif.int_int), 32'd1);
        cif.int_ld_vec = 1'b1; cif.int_vec_mux = 3'd1; tick();
        cif.int_ld_vec = 1'b0; cif.int_vec_mux = 3'd0;
        gate_check("mux_ignore_bus", 16'h0182);
        check("mux_ignore_int", 32'(cif.int_int), 32'd1);
        check("mux_ignore_pend", 32'(int_pend), 32'b0010);
        cif.cpu_pl = 3'd7; tick(); tick();
        check("noint_int", 32'(cif.int_int), 32'd0);
        cif.int_ld_vec = 1'b1; tick(); cif.int_ld_vec = 1'b0;
        gate_check("noint_ignore_bus", 16'h0182);
        check("noint_pend", 32'(int_pend), 32'b0010);

        cif.cpu_pl = 3'd2; tick(); tick();
        cfg_write(1, 0, 4, 'h81);
        tick();
        check("dis_int", 32'(cif.int_int), 32'd0);
        cfg_write(1, 1, 4, 'h81);
        tick(); tick();
`endif
        check("pre_rst_int", 32'(cif.int_int), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_int", 32'(cif.int_int), 32'd0);
        check("mid_rst_pend", 32'(int_pend), 32'd0);
        check("mid_rst_bus", 32'(bus), 32'(PAT));
        gate_check("mid_rst_vec", 16'h0100);
        irq = 4'b0000;

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) irq = 4'($urandom);
            if ($urandom_range(0, 7) == 0) cif.cpu_pl = 3'($urandom_range(0, 7));
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_sel  = 2'($urandom);
            cfg_en   = ($urandom_range(0, 3) != 0);
            cfg_prio = 3'($urandom);
            cfg_vec  = 8'($urandom);
            cif.int_ld_vec   = ($urandom_range(0, 2) == 0);
            cif.int_vec_mux  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            cif.int_gate_vec = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
